// File: rtl/path_result_writer_if.sv
// Engine-side path stream plus bridge-memory write port of the path result writer.
interface path_result_writer_if;
   logic        start_pulse;
   logic        path_valid;
   logic [15:0] path_node_id;
   logic        path_last;
   logic        no_path;
   logic        path_ready;
   logic [5:0]  address;
   logic [15:0] writedata;
   logic        write;
   logic        busy;
   logic        done;

   modport master (
      output start_pulse, path_valid, path_node_id, path_last, no_path,
      input  path_ready, address, writedata, write, busy, done
   );

   modport slave (
      input  start_pulse, path_valid, path_node_id, path_last, no_path,
      output path_ready, address, writedata, write, busy, done
   );
endinterface

// File: rtl/path_result_writer.sv
// Stacks goal-first path beats in a LIFO and writes them start-first to bridge memory, then count, then status last.
// Latency: first path write the cycle after the last accept, done at N+3; path_ready only while collecting, writes never stall.
module path_result_writer #(
   parameter int RESULT_BASE = 34,
   parameter int MAX_PATH    = 28
) (
   input logic                 clk,
   input logic                 reset,
   path_result_writer_if.slave bus
);
   localparam int PW = $clog2(MAX_PATH + 1);
   localparam int IW = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;

   localparam logic [5:0]    ADDR_STATUS = 6'(RESULT_BASE);
   localparam logic [5:0]    ADDR_COUNT  = 6'(RESULT_BASE + 1);
   localparam logic [5:0]    ADDR_PATH   = 6'(RESULT_BASE + 2);
   localparam logic [PW-1:0] PTR_MAX     = PW'(MAX_PATH);
   localparam logic [PW-1:0] PTR_ONE     = PW'(1);

   localparam logic [15:0] ST_BUSY     = 16'h0000;
   localparam logic [15:0] ST_OK       = 16'h0001;
   localparam logic [15:0] ST_NO_PATH  = 16'h0002;
   localparam logic [15:0] ST_OVERFLOW = 16'h0003;

   typedef enum logic [2:0] {
      IDLE, CLEAR, COLLECT, WRITE_PATH, WRITE_COUNT, WRITE_STATUS, DONE
   } state_t;

   state_t          state, state_nxt;
   logic [15:0]     stack [MAX_PATH];
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [PW-1:0]   cnt, cnt_nxt;
   logic            ovf, ovf_nxt;
   logic            np, np_nxt;
   logic            push;
   logic [IW-1:0]   rd_idx, wr_idx;
   logic [15:0]     top;
   logic [5:0]      address, addr_nxt;
   logic [15:0]     writedata, wdata_nxt;
   logic            write, path_ready, busy, done;

   assign bus.address    = address;
   assign bus.writedata  = writedata;
   assign bus.write      = write;
   assign bus.path_ready = path_ready;
   assign bus.busy       = busy;
   assign bus.done       = done;

   assign rd_idx = IW'(ptr - PTR_ONE);
   assign wr_idx = IW'(ptr);
   assign top    = stack[rd_idx];

   // Output registers are loaded one edge ahead, so each write state sees its own word.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      np_nxt    = np;
      addr_nxt  = address;
      wdata_nxt = writedata;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_pulse) begin
               state_nxt = CLEAR;
               addr_nxt  = ADDR_STATUS;
               wdata_nxt = ST_BUSY;
            end
         end
         CLEAR: begin
            ptr_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
            np_nxt    = 1'b0;
            state_nxt = COLLECT;
         end
         COLLECT: begin
            if (bus.no_path) begin
               np_nxt    = 1'b1;
               ptr_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = WRITE_COUNT;
               addr_nxt  = ADDR_COUNT;
               wdata_nxt = 16'h0000;
            end else if (bus.path_valid) begin
               if (ptr < PTR_MAX) begin
                  push    = 1'b1;
                  ptr_nxt = ptr + PTR_ONE;
                  cnt_nxt = cnt + PTR_ONE;
               end else begin
                  ovf_nxt = 1'b1;
               end
               // The final beat is popped straight into the output register as it arrives.
               if (bus.path_last) begin
                  state_nxt = WRITE_PATH;
                  addr_nxt  = ADDR_PATH;
                  wdata_nxt = push ? bus.path_node_id : top;
                  ptr_nxt   = push ? ptr : ptr - PTR_ONE;
               end
            end
         end
         WRITE_PATH: begin
            if (ptr != '0) begin
               wdata_nxt = top;
               ptr_nxt   = ptr - PTR_ONE;
               addr_nxt  = address + 6'd1;
            end else begin
               state_nxt = WRITE_COUNT;
               addr_nxt  = ADDR_COUNT;
               wdata_nxt = 16'(cnt);
            end
         end
         WRITE_COUNT: begin
            state_nxt = WRITE_STATUS;
            addr_nxt  = ADDR_STATUS;
            wdata_nxt = np ? ST_NO_PATH : (ovf ? ST_OVERFLOW : ST_OK);
         end
         WRITE_STATUS: state_nxt = DONE;
         DONE:         state_nxt = IDLE;
         default:      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         ovf        <= 1'b0;
         np         <= 1'b0;
         address    <= '0;
         writedata  <= '0;
         write      <= 1'b0;
         path_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         cnt        <= cnt_nxt;
         ovf        <= ovf_nxt;
         np         <= np_nxt;
         address    <= addr_nxt;
         writedata  <= wdata_nxt;
         write      <= state_nxt inside {CLEAR, WRITE_PATH, WRITE_COUNT, WRITE_STATUS};
         path_ready <= (state_nxt == COLLECT);
         busy       <= state_nxt inside {CLEAR, COLLECT, WRITE_PATH, WRITE_COUNT, WRITE_STATUS};
         done       <= (state_nxt == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (push) stack[wr_idx] <= bus.path_node_id;
   end
endmodule

// File: tb/tb_path_result_writer.sv
// Directed bench for path_result_writer: logs every bridge write and compares against hand-computed sequences.
module tb_path_result_writer;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   path_result_writer_if bus();

   path_result_writer #(.RESULT_BASE(34), .MAX_PATH(28)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [21:0] log_q[$];
   int          log_cyc[$];
   int          done_q[$];
   logic        done_busy_q[$];

   // Monitor: one entry per write strobe, address in the upper bits.
   always @(negedge clk) begin
      if (bus.write) begin
         log_q.push_back({bus.address, bus.writedata});
         log_cyc.push_back(cyc);
      end
      if (bus.done) begin
         done_q.push_back(cyc);
         done_busy_q.push_back(bus.busy);
      end
   end

   int          checks = 0;
   int          failures = 0;
   int          log_base = 0;
   int          done_base = 0;
   logic [21:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic exp_wr(input int addr, input int data);
      exp_q.push_back({6'(addr), 16'(data)});
   endtask

   // Arms the block and returns one ns after the edge that enters COLLECT.
   task automatic begin_txn();
      log_base  = log_q.size();
      done_base = done_q.size();
      exp_q.delete();
      exp_wr(34, 16'h0000);
      bus.start_pulse = 1'b1;
      @(posedge clk); #1;
      bus.start_pulse = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [15:0] id, input logic last, output int acc);
      logic rdy;
      bus.path_valid   = 1'b1;
      bus.path_node_id = id;
      bus.path_last    = last;
      acc = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         rdy = bus.path_ready;
         @(posedge clk); #1;
         if (rdy) begin
            acc = cyc;
            break;
         end
      end
      bus.path_valid = 1'b0;
      bus.path_last  = 1'b0;
      if (acc < 0) check("accept_timeout", 0, 1);
   endtask

   // ref_cyc is the cycle right after the reference edge; that cycle counts as 1.
   task automatic finish_txn(input string tag, input int ref_cyc, input int done_off);
      int n;
      for (int k = 0; k < 200; k++) begin
         if (done_q.size() > done_base) break;
         @(posedge clk); #1;
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      check({tag, "_done_cnt"}, done_q.size() - done_base, 1);
      if (done_q.size() > done_base) begin
         check({tag, "_done_lat"}, done_q[done_base] - ref_cyc + 1, done_off);
         check({tag, "_busy_at_done"}, 32'(done_busy_q[done_base]), 0);
      end
      n = log_q.size() - log_base;
      check({tag, "_nwr"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         check($sformatf("%s_wr%0d", tag, i), log_q[log_base + i], exp_q[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int np_cyc;
      reset            = 1'b1;
      bus.start_pulse  = 1'b0;
      bus.path_valid   = 1'b0;
      bus.path_node_id = 16'h0000;
      bus.path_last    = 1'b0;
      bus.no_path      = 1'b0;
      #3 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_write", 32'(bus.write), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_ready", 32'(bus.path_ready), 0);
      check("rst_addr", 32'(bus.address), 0);
      check("rst_wdata", 32'(bus.writedata), 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Beats offered while idle must be neither accepted nor written.
      log_base = log_q.size();
      bus.path_valid   = 1'b1;
      bus.path_last    = 1'b1;
      bus.path_node_id = 16'h0099;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("idle_ready", 32'(bus.path_ready), 0);
      check("idle_busy", 32'(bus.busy), 0);
      bus.path_valid = 1'b0;
      bus.path_last  = 1'b0;
      check("idle_nwr", log_q.size() - log_base, 0);

      // Three-node path, with a stray start_pulse mid-collect.
      begin_txn();
      check("t1_busy", 32'(bus.busy), 1);
      check("t1_ready", 32'(bus.path_ready), 1);
      send(16'h0005, 1'b0, acc);
      send(16'h0003, 1'b0, acc);
      bus.start_pulse = 1'b1;
      @(posedge clk); #1;
      bus.start_pulse = 1'b0;
      send(16'h0001, 1'b1, acc);
      exp_wr(36, 16'h0001); exp_wr(37, 16'h0003); exp_wr(38, 16'h0005);
      exp_wr(35, 16'h0003); exp_wr(34, 16'h0001);
      finish_txn("t1", acc, 6);
      if (log_q.size() > log_base + 1)
         check("t1_first_wr_lat", log_cyc[log_base + 1] - acc + 1, 1);

      // No route found.
      begin_txn();
      bus.no_path = 1'b1;
      @(posedge clk); #1;
      np_cyc = cyc;
      bus.no_path = 1'b0;
      exp_wr(35, 16'h0000); exp_wr(34, 16'h0002);
      finish_txn("t2", np_cyc, 3);

      // 30 beats into a 28-deep LIFO: the two last beats are dropped.
      begin_txn();
      for (int i = 0; i < 30; i++) send(16'h0100 + 16'(i), i == 29, acc);
      for (int i = 0; i < 28; i++) exp_wr(36 + i, 16'h011B - i);
      exp_wr(35, 16'h001C); exp_wr(34, 16'h0003);
      finish_txn("t3", acc, 31);

      // Exactly full.
      begin_txn();
      for (int i = 0; i < 28; i++) send(16'h0200 + 16'(i), i == 27, acc);
      for (int i = 0; i < 28; i++) exp_wr(36 + i, 16'h021B - i);
      exp_wr(35, 16'h001C); exp_wr(34, 16'h0001);
      finish_txn("t4", acc, 31);

      // Single-node path.
      begin_txn();
      send(16'h0042, 1'b1, acc);
      exp_wr(36, 16'h0042); exp_wr(35, 16'h0001); exp_wr(34, 16'h0001);
      finish_txn("t5", acc, 4);

      // Gaps between beats.
      begin_txn();
      send(16'h0010, 1'b0, acc);
      repeat (2) begin
         @(posedge clk); #1;
      end
      send(16'h0020, 1'b0, acc);
      repeat (3) begin
         @(posedge clk); #1;
      end
      send(16'h0030, 1'b1, acc);
      exp_wr(36, 16'h0030); exp_wr(37, 16'h0020); exp_wr(38, 16'h0010);
      exp_wr(35, 16'h0003); exp_wr(34, 16'h0001);
      finish_txn("t6", acc, 6);

      // no_path colliding with a valid last beat.
      begin_txn();
      send(16'h0077, 1'b0, acc);
      bus.path_valid   = 1'b1;
      bus.path_node_id = 16'h0088;
      bus.path_last    = 1'b1;
      bus.no_path      = 1'b1;
      @(posedge clk); #1;
      np_cyc = cyc;
      bus.path_valid = 1'b0;
      bus.path_last  = 1'b0;
      bus.no_path    = 1'b0;
      exp_wr(35, 16'h0000); exp_wr(34, 16'h0002);
      finish_txn("t6c", np_cyc, 3);

      // Reset while the path is being written.
      begin_txn();
      for (int i = 0; i < 5; i++) send(16'h0500 + 16'(i), i == 4, acc);
      check("t7_write_before", 32'(bus.write), 1);
      #1 reset = 1'b0;
      #1;
      check("t7_write_abort", 32'(bus.write), 0);
      check("t7_busy_abort", 32'(bus.busy), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("t7_nwr_aborted", log_q.size() - log_base, 1);
      check("t7_done_aborted", done_q.size() - done_base, 0);

      begin_txn();
      send(16'h00A1, 1'b0, acc);
      send(16'h00A2, 1'b1, acc);
      exp_wr(36, 16'h00A2); exp_wr(37, 16'h00A1);
      exp_wr(35, 16'h0002); exp_wr(34, 16'h0001);
      finish_txn("t7", acc, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
